// File: rtl/fp32_pkg.sv
// fp32_pkg: shared constants and enums for the iterative binary32 divider
package fp32_pkg;
  localparam logic [9:0] EXP_BIAS = 10'd127;
  localparam logic [9:0] EXP_MAX = 10'd255;
  localparam logic [31:0] QNAN = 32'h7FC00000;
  localparam logic [31:0] POS_INF = 32'h7F800000;
  typedef enum logic [1:0] {ST_IDLE, ST_CALC, ST_NORM, ST_DONE} state_t;
  typedef enum logic [1:0] {CL_ZERO, CL_NORM, CL_INF, CL_NAN} op_class_t;
endpackage

// File: rtl/fp32_classify.sv
// fp32_classify: sorts a binary32 operand into zero, normal, inf or NaN
module fp32_classify
  import fp32_pkg::*;
(
  input  logic [31:0] x,
  output logic [1:0]  cls
);
  logic unused_sign;
  always_comb begin
    unused_sign = x[31];
    cls = (x[30:23] == 8'h00) ? CL_ZERO :
          (x[30:23] != 8'hFF) ? CL_NORM :
          (x[22:0] == 23'd0)  ? CL_INF  : CL_NAN;
  end
endmodule

// File: rtl/fp32_div_iter.sv
// fp32_div_iter: multi-cycle binary32 divider, one restoring quotient bit per cycle
module fp32_div_iter
  import fp32_pkg::*;
(
  input  logic        clk,
  input  logic        rst_n,
  input  logic        start,
  input  logic [31:0] a,
  input  logic [31:0] b,
  output logic        ready,
  output logic        done,
  output logic [31:0] q,
  output logic        overflow,
  output logic        underflow,
  output logic        div_by_zero,
  output logic        invalid
);
  state_t state;
  logic [1:0] ca, cb, ca_r, cb_r;
  logic sign;
  logic [23:0] dvs;
  logic [25:0] rem, quo, diff;
  logic [4:0] cnt;
  logic [9:0] exp_r, e1, e2;
  logic [23:0] sig;
  logic [24:0] rnd;
  logic [22:0] frac;
  logic [31:0] nq;
  logic accept, special, ge, grd, stk, rup, nrm, nan, zro, inf, ovf, unf, dz;
  fp32_classify u_cls_a (.x(a), .cls(ca));
  fp32_classify u_cls_b (.x(b), .cls(cb));
  always_comb begin
    accept = start & ready;
    special = (ca != CL_NORM) | (cb != CL_NORM);
    ge = rem >= {2'b00, dvs};
    diff = ge ? rem - {2'b00, dvs} : rem;
    e1 = exp_r - {9'd0, ~quo[25]};
    sig = quo[25] ? quo[25:2] : quo[24:1];
    grd = quo[25] ? quo[1] : quo[0];
    stk = (quo[25] & quo[0]) | (|rem);
    rup = grd & (stk | sig[0]);
    rnd = {1'b0, sig} + {24'd0, rup};
    e2 = e1 + {9'd0, rnd[24]};
    frac = rnd[24] ? rnd[23:1] : rnd[22:0];
    nrm = (ca_r == CL_NORM) & (cb_r == CL_NORM);
    nan = (ca_r == CL_NAN) | (cb_r == CL_NAN) |
          ((ca_r == cb_r) & ((ca_r == CL_ZERO) | (ca_r == CL_INF)));
    dz = (ca_r == CL_NORM) & (cb_r == CL_ZERO);
    ovf = nrm & ~e2[9] & (e2 >= EXP_MAX);
    unf = nrm & (e2[9] | (e2 == 10'd0));
    zro = (ca_r == CL_ZERO) | (cb_r == CL_INF) | unf;
    inf = (ca_r == CL_INF) | dz | ovf;
    nq = nan ? QNAN :
         zro ? {sign, 31'd0} :
         inf ? (POS_INF | {sign, 31'd0}) : {sign, e2[7:0], frac};
  end
  always_ff @(posedge clk or negedge rst_n)
    if (!rst_n) begin
      state <= ST_IDLE;
      ready <= 1'b1;
      done <= 1'b0;
      q <= 32'd0;
      {overflow, underflow, div_by_zero, invalid} <= 4'd0;
      {ca_r, cb_r, sign} <= 5'd0;
      dvs <= 24'd0;
      rem <= 26'd0;
      quo <= 26'd0;
      cnt <= 5'd0;
      exp_r <= 10'd0;
    end else begin
      done <= 1'b0;
      if (accept) begin
        state <= special ? ST_NORM : ST_CALC;
        ready <= 1'b0;
        {overflow, underflow, div_by_zero, invalid} <= 4'd0;
        ca_r <= ca;
        cb_r <= cb;
        sign <= a[31] ^ b[31];
        dvs <= {1'b1, b[22:0]};
        rem <= {3'b001, a[22:0]};
        quo <= 26'd0;
        cnt <= 5'd0;
        exp_r <= {2'b00, a[30:23]} - {2'b00, b[30:23]} + EXP_BIAS;
      end else
        case (state)
          ST_CALC: begin
            rem <= diff << 1;
            quo <= {quo[24:0], ge};
            cnt <= cnt + 5'd1;
            state <= (cnt == 5'd25) ? ST_NORM : ST_CALC;
          end
          ST_NORM: begin
            q <= nq;
            {overflow, underflow, div_by_zero, invalid} <= {ovf, unf, dz, nan};
            done <= 1'b1;
            ready <= 1'b1;
            state <= ST_DONE;
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
    end
endmodule

// File: tb/tb_fp32_div_iter.sv
// tb_fp32_div_iter: directed-vector bench for the iterative binary32 divider
module tb_fp32_div_iter;
  typedef struct packed {
    logic [31:0] a;
    logic [31:0] b;
    logic [31:0] q;
    logic [3:0]  f;
  } vec_t;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic start = 1'b0;
  logic [31:0] a = 32'd0;
  logic [31:0] b = 32'd0;
  logic ready, done, overflow, underflow, div_by_zero, invalid;
  logic [31:0] q;
  int vecs = 0;
  int errs = 0;
  always #5 clk = ~clk;
  fp32_div_iter dut (
    .clk(clk), .rst_n(rst_n), .start(start), .a(a), .b(b),
    .ready(ready), .done(done), .q(q), .overflow(overflow),
    .underflow(underflow), .div_by_zero(div_by_zero), .invalid(invalid)
  );
  task automatic launch(input logic [31:0] xa, input logic [31:0] xb);
    @(negedge clk);
    a = xa;
    b = xb;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
  endtask
  task automatic wait_done(inout int n);
    while (n < 100) begin
      @(negedge clk);
      n++;
      if (done) return;
    end
    n = -1;
  endtask
  task automatic test_reset;
    repeat (2) @(negedge clk);
    vecs++;
    if ({ready, done, overflow, underflow, div_by_zero, invalid, q} !== {1'b1, 5'd0, 32'd0}) begin
      errs++;
      $display("FAIL reset: got ready/done/flags/q=%b%b%b%b%b%b %h want 100000 00000000",
               ready, done, overflow, underflow, div_by_zero, invalid, q);
    end
    rst_n = 1'b1;
  endtask
  task automatic test_normal;
    vec_t v[6];
    int n;
    v[0] = {32'h40C00000, 32'h40000000, 32'h40400000, 4'b0000};
    v[1] = {32'h3F800000, 32'h40400000, 32'h3EAAAAAB, 4'b0000};
    v[2] = {32'h3F800000, 32'h3F800000, 32'h3F800000, 4'b0000};
    v[3] = {32'hC0C00000, 32'h40000000, 32'hC0400000, 4'b0000};
    v[4] = {32'h3F800000, 32'h40000000, 32'h3F000000, 4'b0000};
    v[5] = {32'h40000000, 32'h40400000, 32'h3F2AAAAB, 4'b0000};
    foreach (v[i]) begin
      launch(v[i].a, v[i].b);
      n = 0;
      wait_done(n);
      vecs++;
      if (q !== v[i].q || {overflow, underflow, div_by_zero, invalid} !== v[i].f || n != 28) begin
        errs++;
        $display("FAIL normal[%0d]: got q=%h flags=%b lat=%0d want q=%h flags=%b lat=28",
                 i, q, {overflow, underflow, div_by_zero, invalid}, n, v[i].q, v[i].f);
      end
      @(negedge clk);
      vecs++;
      if (done !== 1'b0) begin
        errs++;
        $display("FAIL done_width[%0d]: done=%b one cycle after pulse, want 0", i, done);
      end
    end
  endtask
  task automatic test_special;
    vec_t v[10];
    int n;
    v[0] = {32'h3F800000, 32'h00000000, 32'h7F800000, 4'b0010};
    v[1] = {32'hBF800000, 32'h00000000, 32'hFF800000, 4'b0010};
    v[2] = {32'h00000000, 32'h00000000, 32'h7FC00000, 4'b0001};
    v[3] = {32'h7F800000, 32'h7F800000, 32'h7FC00000, 4'b0001};
    v[4] = {32'h7F800001, 32'h3F800000, 32'h7FC00000, 4'b0001};
    v[5] = {32'h00000000, 32'h40000000, 32'h00000000, 4'b0000};
    v[6] = {32'h80000000, 32'h40000000, 32'h80000000, 4'b0000};
    v[7] = {32'h40000000, 32'h7F800000, 32'h00000000, 4'b0000};
    v[8] = {32'h7F800000, 32'hC0000000, 32'hFF800000, 4'b0000};
    v[9] = {32'h7F800000, 32'h00000000, 32'h7F800000, 4'b0000};
    foreach (v[i]) begin
      launch(v[i].a, v[i].b);
      n = 0;
      wait_done(n);
      vecs++;
      if (q !== v[i].q || {overflow, underflow, div_by_zero, invalid} !== v[i].f || n != 2) begin
        errs++;
        $display("FAIL special[%0d]: got q=%h flags=%b lat=%0d want q=%h flags=%b lat=2",
                 i, q, {overflow, underflow, div_by_zero, invalid}, n, v[i].q, v[i].f);
      end
    end
  endtask
  task automatic test_range;
    vec_t v[4];
    int n;
    v[0] = {32'h7F000000, 32'h00800000, 32'h7F800000, 4'b1000};
    v[1] = {32'h00800000, 32'h40000000, 32'h00000000, 4'b0100};
    v[2] = {32'hFF000000, 32'h00800000, 32'hFF800000, 4'b1000};
    v[3] = {32'h00800000, 32'h3F800000, 32'h00800000, 4'b0000};
    foreach (v[i]) begin
      launch(v[i].a, v[i].b);
      n = 0;
      wait_done(n);
      vecs++;
      if (q !== v[i].q || {overflow, underflow, div_by_zero, invalid} !== v[i].f || n != 28) begin
        errs++;
        $display("FAIL range[%0d]: got q=%h flags=%b lat=%0d want q=%h flags=%b lat=28",
                 i, q, {overflow, underflow, div_by_zero, invalid}, n, v[i].q, v[i].f);
      end
    end
  endtask
  task automatic test_busy_start;
    int n = 0;
    launch(32'h40C00000, 32'h40000000);
    repeat (5) begin
      @(negedge clk);
      n++;
    end
    a = 32'h3F800000;
    b = 32'h40400000;
    start = 1'b1;
    @(negedge clk);
    n++;
    start = 1'b0;
    wait_done(n);
    vecs++;
    if (q !== 32'h40400000 || n != 28) begin
      errs++;
      $display("FAIL busy_start: got q=%h lat=%0d want q=40400000 lat=28", q, n);
    end
  endtask
  task automatic test_back_to_back;
    int n = 0;
    launch(32'h3F800000, 32'h40400000);
    wait_done(n);
    vecs++;
    if (q !== 32'h3EAAAAAB || ready !== 1'b1 || n != 28) begin
      errs++;
      $display("FAIL b2b_first: got q=%h ready=%b lat=%0d want q=3eaaaaab ready=1 lat=28", q, ready, n);
    end
    a = 32'h40C00000;
    b = 32'h40000000;
    start = 1'b1;
    @(posedge clk);
    #1 start = 1'b0;
    n = 0;
    wait_done(n);
    vecs++;
    if (q !== 32'h40400000 || n != 28) begin
      errs++;
      $display("FAIL b2b_second: got q=%h lat=%0d want q=40400000 lat=28", q, n);
    end
  endtask
  task automatic test_abort;
    int n = 0;
    int pulses = 0;
    launch(32'h40C00000, 32'h40000000);
    repeat (10) @(negedge clk);
    rst_n = 1'b0;
    #1;
    vecs++;
    if ({ready, done, overflow, underflow, div_by_zero, invalid, q} !== {1'b1, 5'd0, 32'd0}) begin
      errs++;
      $display("FAIL abort_reset: got ready/done/flags/q=%b%b%b%b%b%b %h want 100000 00000000",
               ready, done, overflow, underflow, div_by_zero, invalid, q);
    end
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    repeat (30) begin
      @(negedge clk);
      if (done) pulses++;
    end
    vecs++;
    if (pulses != 0) begin
      errs++;
      $display("FAIL abort_done: got %0d done pulses want 0", pulses);
    end
    launch(32'h40C00000, 32'h40000000);
    wait_done(n);
    vecs++;
    if (q !== 32'h40400000 || n != 28) begin
      errs++;
      $display("FAIL abort_restart: got q=%h lat=%0d want q=40400000 lat=28", q, n);
    end
  endtask
  initial begin
    test_reset();
    test_normal();
    test_special();
    test_range();
    test_busy_start();
    test_back_to_back();
    test_abort();
    $display("== %0d vectors applied, %0d miscompares ==", vecs, errs);
    $finish;
  end
  initial begin
    #500000;
    $display("FAIL watchdog: simulation exceeded time limit");
    $fatal(1);
  end
endmodule
